dma_stream_ctrl: RTL
====================

// Module: dma_stream_ctrl
// PURPOSE
//  Sequences the read and write dma_streamer instances through a table of up to NUM_DESC descriptors.
//  On dma_go_i it walks the enabled table entries in index order. For each entry it drives the entry
//  to both streamers and holds both stream valids until each streamer has pulsed done.
//  Sits between the CSR block and the two streamers. Provides abort, a per-descriptor watchdog and
//  first-error capture.
// PARAMETERS
//  NUM_DESC   4   descriptor table depth (>=1); IDX_W = max(1,$clog2(NUM_DESC))
//  TIMEOUT_W  16  width of the watchdog counter and of dma_timeout_i
// PORTS
//  clk             in   1                    clock
//  rstn            in   1                    reset, asynchronous, active-low
//  dma_go_i        in   1                    start pulse from CSRs; sampled only in IDLE
//  dma_abort_i     in   1                    abort request, level; sampled in SEL/RUN
//  dma_desc_i      in   NUM_DESC x s_dma_desc_t  descriptor table from CSRs
//  dma_desc_en_i   in   NUM_DESC             per-entry enable
//  dma_timeout_i   in   TIMEOUT_W            watchdog limit in cycles per descriptor; 0 = disabled
//  dma_desc_o      out  s_dma_desc_t         registered descriptor to both streamers
//  dma_rd_valid_o  out  1                    stream valid to read streamer
//  dma_wr_valid_o  out  1                    stream valid to write streamer
//  dma_rd_done_i   in   1                    done pulse, read streamer
//  dma_wr_done_i   in   1                    done pulse, write streamer
//  dma_rd_err_i    in   s_dma_error_t        read streamer error (valid is sticky at source)
//  dma_wr_err_i    in   s_dma_error_t        write streamer error
//  dma_active_o    out  1                    state != IDLE
//  dma_done_o      out  1                    1-cycle pulse: table completed normally
//  dma_abort_o     out  1                    1-cycle pulse: abort drain completed
//  dma_error_o     out  s_dma_error_t        first captured streamer error, sticky
//  dma_err_dir_o   out  1                    0 = read streamer, 1 = write streamer
//  dma_timeout_o   out  1                    watchdog expired, sticky
//  dma_desc_idx_o  out  IDX_W                index of the current/last descriptor
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, idx 0, rd/wr done-seen flags 0, prev-err-valid flags 0.
//  All outputs are registered.
//  States:
//  - IDLE: dma_go_i=1 -> SEL with idx=0.
//  - SEL: abort -> IDLE, with dma_abort_o pulsed. Otherwise take the lowest enabled entry j>=idx:
//    latch dma_desc_o=dma_desc_i[j], set idx=j, raise both valids next cycle, clear the done-seen
//    flags and the watchdog, then -> RUN. If no enabled entry remains: -> IDLE and pulse dma_done_o.
//  - RUN: a streamer's done pulse sets its seen-flag; that streamer's valid is 0 from the next cycle.
//    - Both seen: if idx==NUM_DESC-1 -> IDLE and pulse dma_done_o; else idx+1 -> SEL.
//    - SEL adds >=1 cycle with both valids low between descriptors.
//  - ABORT: abort in RUN -> ABORT. Both valids are 0 the next cycle. Wait for done on every streamer
//    not yet seen, then -> IDLE and pulse dma_abort_o.
//  - ERR: terminal until rstn; valids 0; dma_go_i ignored; dma_active_o=1.
//  Error capture:
//  - Only a 0->1 edge of err.valid counts, comparing against the registered previous value.
//  - Checked in RUN/ABORT; any edge -> ERR.
//  - dma_error_o/dma_err_dir_o take the first error. Read wins on a same-cycle error; it is never overwritten.
//  Watchdog:
//  - The counter counts cycles in RUN/ABORT and saturates at all-ones.
//  - When it reaches dma_timeout_i (nonzero) -> ERR and set dma_timeout_o.
//  Priority in one cycle: error > timeout > abort > done.
//  - A done in the same cycle as an abort still sets its seen-flag.
//  dma_go_i outside IDLE is ignored. dma_desc_i changes after SEL latch do not affect dma_desc_o.
//  Reset mid-operation: asynchronous return to reset values. Streamers are reset by the same rstn.
// TESTING
//  - Table en=4'b0101, rd done @+10, wr done @+14 -> idx 0 then 2; valid gap >=1 cycle;
//    dma_done_o 1 pulse; done never repeats.
//  - en=0, go -> SEL -> IDLE; dma_done_o pulsed 2 cycles after go; valids never 1.
//  - Abort @ RUN+3, rd done @+5, wr done @+9 -> valids 0 at RUN+4; dma_abort_o 1 cycle after wr done.
//  - wr_err.valid rises in RUN with addr 0x1004 -> ERR; dma_error_o.addr=0x1004; dma_err_dir_o=1;
//    later go ignored.
//  - dma_timeout_i=20, no dones -> ERR and dma_timeout_o=1 exactly 20 cycles into RUN.
//    With dma_timeout_i=0 there is no timeout after 70000 cycles.
//  - rstn low mid-RUN, then a new go -> all outputs 0 immediately; a new go starts at idx 0.

Source files
------------

// File: rtl/dma_stream_ctrl.sv
// Descriptor-table sequencer for the read/write dma_streamer pair.
// It walks the enabled entries and supports abort, a per-descriptor watchdog and first-error capture.
package dma_stream_pkg;
  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
  } s_dma_desc_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } s_dma_error_t;
endpackage

module dma_stream_ctrl
  import dma_stream_pkg::*;
#(
  parameter int NUM_DESC  = 4,
  parameter int TIMEOUT_W = 16,
  localparam int IDX_W    = (NUM_DESC > 1) ? $clog2(NUM_DESC) : 1
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           dma_go_i,
  input  logic                           dma_abort_i,
  input  s_dma_desc_t [NUM_DESC-1:0]     dma_desc_i,
  input  logic [NUM_DESC-1:0]            dma_desc_en_i,
  input  logic [TIMEOUT_W-1:0]           dma_timeout_i,
  output s_dma_desc_t                    dma_desc_o,
  output logic                           dma_rd_valid_o,
  output logic                           dma_wr_valid_o,
  input  logic                           dma_rd_done_i,
  input  logic                           dma_wr_done_i,
  input  s_dma_error_t                   dma_rd_err_i,
  input  s_dma_error_t                   dma_wr_err_i,
  output logic                           dma_active_o,
  output logic                           dma_done_o,
  output logic                           dma_abort_o,
  output s_dma_error_t                   dma_error_o,
  output logic                           dma_err_dir_o,
  output logic                           dma_timeout_o,
  output logic [IDX_W-1:0]               dma_desc_idx_o,
  output logic [2:0]                     dma_state_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_RUN   = 3'd2,
    ST_ABORT = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // Handshake: each stream valid rises together with a freshly latched dma_desc_o and stays
  // high until that streamer's done pulse is sampled; done is a single-cycle pulse per descriptor.
  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  s_dma_desc_t          desc_q, desc_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 wr_valid_q, wr_valid_d;
  logic                 rd_seen_q, rd_seen_d;
  logic                 wr_seen_q, wr_seen_d;
  logic                 prev_rd_q, prev_wr_q;
  s_dma_error_t         err_q, err_d;
  logic                 err_dir_q, err_dir_d;
  logic                 tmo_q, tmo_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 done_q, done_d;
  logic                 abort_q, abort_d;
  logic                 active_q;

  logic                 sel_found;
  logic [IDX_W-1:0]     sel_idx;
  logic [TIMEOUT_W-1:0] wd_inc;
  logic                 wd_hit;
  logic                 rd_rise, wr_rise;
  logic                 rd_all, wr_all;
  logic                 last_idx;

  // Lowest enabled entry at or above the current index; descending scan so the lowest wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int j = NUM_DESC - 1; j >= 0; j--) begin
      if (dma_desc_en_i[j] && (j >= int'(idx_q))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(j);
      end
    end
  end

  assign wd_inc   = (&wd_q) ? wd_q : wd_q + TIMEOUT_W'(1);
  assign wd_hit   = (dma_timeout_i != '0) && (wd_inc >= dma_timeout_i);
  assign rd_rise  = dma_rd_err_i.valid & ~prev_rd_q;
  assign wr_rise  = dma_wr_err_i.valid & ~prev_wr_q;
  assign rd_all   = rd_seen_q | dma_rd_done_i;
  assign wr_all   = wr_seen_q | dma_wr_done_i;
  assign last_idx = (idx_q == IDX_W'(NUM_DESC - 1));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    desc_d     = desc_q;
    rd_valid_d = 1'b0;
    wr_valid_d = 1'b0;
    rd_seen_d  = rd_seen_q;
    wr_seen_d  = wr_seen_q;
    err_d      = err_q;
    err_dir_d  = err_dir_q;
    tmo_d      = tmo_q;
    wd_d       = wd_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dma_go_i) begin
          state_d = ST_SEL;
          idx_d   = '0;
        end
      end

      ST_SEL: begin
        if (dma_abort_i) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else if (sel_found) begin
          state_d    = ST_RUN;
          idx_d      = sel_idx;
          desc_d     = dma_desc_i[sel_idx];
          rd_valid_d = 1'b1;
          wr_valid_d = 1'b1;
          rd_seen_d  = 1'b0;
          wr_seen_d  = 1'b0;
          wd_d       = '0;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      ST_RUN, ST_ABORT: begin
        wd_d = wd_inc;
        if (rd_rise || wr_rise) begin
          state_d = ST_ERR;
          if (!err_q.valid) begin
            err_d     = rd_rise ? dma_rd_err_i : dma_wr_err_i;
            err_dir_d = ~rd_rise;
          end
        end else if (wd_hit) begin
          state_d = ST_ERR;
          tmo_d   = 1'b1;
        end else if ((state_q == ST_RUN) && dma_abort_i) begin
          // Dones arriving with the abort still count, so the drain does not wait for them again.
          state_d   = ST_ABORT;
          rd_seen_d = rd_all;
          wr_seen_d = wr_all;
        end else begin
          rd_seen_d = rd_all;
          wr_seen_d = wr_all;
          if (state_q == ST_RUN) begin
            if (rd_all && wr_all) begin
              if (last_idx) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_SEL;
                idx_d   = idx_q + IDX_W'(1);
              end
            end else begin
              rd_valid_d = ~rd_all;
              wr_valid_d = ~wr_all;
            end
          end else if (rd_all && wr_all) begin
            state_d = ST_IDLE;
            abort_d = 1'b1;
          end
        end
      end

      ST_ERR: begin
        state_d = ST_ERR;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      desc_q     <= '0;
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_seen_q  <= 1'b0;
      wr_seen_q  <= 1'b0;
      prev_rd_q  <= 1'b0;
      prev_wr_q  <= 1'b0;
      err_q      <= '0;
      err_dir_q  <= 1'b0;
      tmo_q      <= 1'b0;
      wd_q       <= '0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      desc_q     <= desc_d;
      rd_valid_q <= rd_valid_d;
      wr_valid_q <= wr_valid_d;
      rd_seen_q  <= rd_seen_d;
      wr_seen_q  <= wr_seen_d;
      prev_rd_q  <= dma_rd_err_i.valid;
      prev_wr_q  <= dma_wr_err_i.valid;
      err_q      <= err_d;
      err_dir_q  <= err_dir_d;
      tmo_q      <= tmo_d;
      wd_q       <= wd_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      active_q   <= (state_d != ST_IDLE);
    end
  end

  assign dma_desc_o     = desc_q;
  assign dma_rd_valid_o = rd_valid_q;
  assign dma_wr_valid_o = wr_valid_q;
  assign dma_active_o   = active_q;
  assign dma_done_o     = done_q;
  assign dma_abort_o    = abort_q;
  assign dma_error_o    = err_q;
  assign dma_err_dir_o  = err_dir_q;
  assign dma_timeout_o  = tmo_q;
  assign dma_desc_idx_o = idx_q;
  assign dma_state_o    = state_q;

endmodule
